breakout_game_ctrl: RTL and testbench
=====================================

// Module: breakout_game_ctrl
// PURPOSE
//  Game-flow sequencer for Breakout: owns game state, lives and brick tally.
//  Sits beside bar/ball/brick animators and gameover overlay. Gates their motion
//  (freeze), releases the ball (serve), re-arms all objects (game_rst).
//  Reports gameover/win/score to the RGB mux and LEDs.
// PARAMETERS
//  NUM_BRICKS   7    brick rows monitored; width of brick_p
//  LIVES        3    balls per game, 1..3
//  SERVE_TICKS  60   tick60hz ticks ball rests on paddle before auto-serve
//  MISS_TICKS   90   tick60hz ticks of pause after a lost ball
//  HOLD_TICKS   120  ticks OVER/WIN ignores buttons before restart allowed
//  CNT_W        8    tick counter width; every *_TICKS < 2**CNT_W
// PORTS
//  clk           in   1           system clock
//  reset         in   1           async reset, ACTIVE-LOW (0 = reset)
//  tick60hz      in   1           1-clk frame strobe
//  btn           in   2           player buttons, level, synchronous to clk
//  ball_miss     in   1           1-clk pulse: ball passed below paddle
//  brick_p       in   NUM_BRICKS  1 = brick present, per brick
//  freeze        out  1           1 = bar/ball hold position
//  serve         out  1           1-clk pulse: launch ball from paddle
//  game_rst      out  1           1-clk pulse: restore bricks, centre ball/bar
//  gameover      out  1           1 in OVER
//  win           out  1           1 in WIN
//  lives         out  2           balls remaining
//  bricks_taken  out  4           registered count of zero bits in brick_p
//  state         out  3           encoded FSM state, debug
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, freeze=1, serve=0, game_rst=0,
//   gameover=0, win=0, lives=LIVES, bricks_taken=0, tick cnt=0, btn_q=0.
//  btn_q registers btn each clk; press = |(btn & ~btn_q), a rising edge.
//  All outputs registered; transitions take effect on the clk edge after cause.
//  States (encoding): IDLE=0 SERVE=1 PLAY=2 MISS=3 OVER=4 WIN=5.
//  IDLE: freeze=1. On press: pulse game_rst, lives<=LIVES, cnt<=0, ->SERVE.
//  SERVE: freeze=1. cnt increments on tick60hz. On press or
//   cnt==SERVE_TICKS-1 with tick: pulse serve, ->PLAY.
//  PLAY: freeze=0. Priority per clk, highest first:
//   1) brick_p==0          -> WIN
//   2) ball_miss, lives==1 -> lives<=0, OVER, cnt<=0
//   3) ball_miss, lives>1  -> lives<=lives-1, MISS, cnt<=0
//   Clearing the last brick in the same clk as a miss -> WIN, lives unchanged.
//  MISS: freeze=1. cnt==MISS_TICKS-1 with tick: cnt<=0, ->SERVE. Buttons ignored.
//  OVER/WIN: freeze=1, gameover/win=1. cnt counts ticks, saturates at
//   HOLD_TICKS. Press while cnt<HOLD_TICKS is ignored. Press at cnt==HOLD_TICKS
//   -> IDLE, gameover/win cleared.
//  ball_miss outside PLAY is ignored. serve and game_rst last exactly 1 clk.
//  Both pulses never occur in the same clk.
//  bricks_taken = popcount(~brick_p), updated every clk, range 0..NUM_BRICKS.
//   Not masked by state.
//  Counter: cnt cleared on every state entry; never wraps.
//  Illegal state encodings -> IDLE on next clk.
//  Reset mid-game: immediate IDLE, all outputs to reset values.
//   No game_rst pulse until the next press.
// TESTING
//  1 reset low 3 clk, release; btn=01 one clk -> game_rst 1 clk, state=SERVE,
//    lives=3, freeze=1
//  2 SERVE, no buttons, 60 ticks -> serve pulse on 60th tick clk, state=PLAY,
//    freeze=0
//  3 PLAY lives=3, ball_miss pulse -> lives=2, MISS; 90 ticks -> SERVE;
//    repeat to lives=1; miss -> lives=0, OVER, gameover=1
//  4 OVER: press at tick 50 -> stays OVER; press after 120 ticks -> IDLE,
//    gameover=0
//  5 PLAY, brick_p 0000001->0000000 same clk as ball_miss -> WIN, win=1,
//    lives unchanged, bricks_taken=7
//  6 PLAY: assert reset=0 mid-frame -> state=IDLE, freeze=1, lives=3,
//    bricks_taken=0 asynchronously

Source files
------------

// File: rtl/breakout_game_ctrl_if.sv
// Breakout game-flow bus: frame strobe, player/ball/brick inputs and the
// sequencer's freeze/serve/reset controls plus status back to the display.
interface breakout_game_ctrl_if #(
   parameter int NUM_BRICKS = 7
);
   logic                  tick60hz;
   logic [1:0]            btn;
   logic                  ball_miss;
   logic [NUM_BRICKS-1:0] brick_p;
   logic                  freeze;
   logic                  serve;
   logic                  game_rst;
   logic                  gameover;
   logic                  win;
   logic [1:0]            lives;
   logic [3:0]            bricks_taken;
   logic [2:0]            state;

   // Environment side: drives game events, observes controls and status.
   modport master (
      output tick60hz, btn, ball_miss, brick_p,
      input  freeze, serve, game_rst, gameover, win, lives, bricks_taken, state
   );

   // Sequencer side.
   modport slave (
      input  tick60hz, btn, ball_miss, brick_p,
      output freeze, serve, game_rst, gameover, win, lives, bricks_taken, state
   );
endinterface

// File: rtl/breakout_game_ctrl.sv
// Breakout game-flow sequencer: tracks game state, remaining balls and the
// number of bricks knocked out; freezes/serves/re-arms the object animators.
module breakout_game_ctrl #(
   parameter int NUM_BRICKS  = 7,
   parameter int LIVES       = 3,
   parameter int SERVE_TICKS = 60,
   parameter int MISS_TICKS  = 90,
   parameter int HOLD_TICKS  = 120,
   parameter int CNT_W       = 8
) (
   input logic                 clk,
   input logic                 reset,
   breakout_game_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_MISS  = 3'd3,
      ST_OVER  = 3'd4,
      ST_WIN   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0]      SERVE_LAST = CNT_W'(SERVE_TICKS - 1);
   localparam logic [CNT_W-1:0]      MISS_LAST  = CNT_W'(MISS_TICKS - 1);
   localparam logic [CNT_W-1:0]      HOLD_MAX   = CNT_W'(HOLD_TICKS);
   localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]      CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [1:0]            LIVES_INIT = 2'(LIVES);
   localparam logic [NUM_BRICKS-1:0] NO_BRICKS  = {NUM_BRICKS{1'b0}};

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       lives_r;
   logic [1:0]       btn_q_r;
   logic             freeze_r;
   logic             serve_r;
   logic             game_rst_r;
   logic             gameover_r;
   logic             win_r;
   logic [3:0]       bricks_taken_r;
   logic             press_s;

   // Number of cleared bricks (zero bits) in the presence vector.
   function automatic logic [3:0] count_cleared(input logic [NUM_BRICKS-1:0] bricks);
      logic [3:0] total;
      total = 4'd0;
      for (int i = 0; i < NUM_BRICKS; i++) begin
         total = total + {3'd0, ~bricks[i]};
      end
      return total;
   endfunction

   // A press is a rising edge on either button.
   assign press_s = |(bus.btn & ~btn_q_r);

   // Previous button levels for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q_r <= 2'b00;
      end else begin
         btn_q_r <= bus.btn;
      end
   end

   // Brick tally follows the brick vector every clock regardless of state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bricks_taken_r <= 4'd0;
      end else begin
         bricks_taken_r <= count_cleared(bus.brick_p);
      end
   end

   // Game-flow FSM; status outputs are updated together with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         lives_r    <= LIVES_INIT;
         freeze_r   <= 1'b1;
         serve_r    <= 1'b0;
         game_rst_r <= 1'b0;
         gameover_r <= 1'b0;
         win_r      <= 1'b0;
      end else begin
         serve_r    <= 1'b0;
         game_rst_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (press_s) begin
                  game_rst_r <= 1'b1;
                  lives_r    <= LIVES_INIT;
                  cnt_r      <= CNT_ZERO;
                  state_r    <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (press_s || (bus.tick60hz && (cnt_r == SERVE_LAST))) begin
                  serve_r  <= 1'b1;
                  freeze_r <= 1'b0;
                  cnt_r    <= CNT_ZERO;
                  state_r  <= ST_PLAY;
               end else if (bus.tick60hz) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_PLAY: begin
               // Clearing the last brick outranks a simultaneous miss.
               if (bus.brick_p == NO_BRICKS) begin
                  freeze_r <= 1'b1;
                  win_r    <= 1'b1;
                  cnt_r    <= CNT_ZERO;
                  state_r  <= ST_WIN;
               end else if (bus.ball_miss && (lives_r <= 2'd1)) begin
                  lives_r    <= 2'd0;
                  freeze_r   <= 1'b1;
                  gameover_r <= 1'b1;
                  cnt_r      <= CNT_ZERO;
                  state_r    <= ST_OVER;
               end else if (bus.ball_miss) begin
                  lives_r  <= lives_r - 2'd1;
                  freeze_r <= 1'b1;
                  cnt_r    <= CNT_ZERO;
                  state_r  <= ST_MISS;
               end
            end
            ST_MISS: begin
               if (bus.tick60hz && (cnt_r == MISS_LAST)) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= ST_SERVE;
               end else if (bus.tick60hz) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_OVER, ST_WIN: begin
               // Buttons only count once the hold-off has fully elapsed.
               if (press_s && (cnt_r == HOLD_MAX)) begin
                  gameover_r <= 1'b0;
                  win_r      <= 1'b0;
                  cnt_r      <= CNT_ZERO;
                  state_r    <= ST_IDLE;
               end else if (bus.tick60hz && (cnt_r < HOLD_MAX)) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= CNT_ZERO;
               freeze_r   <= 1'b1;
               gameover_r <= 1'b0;
               win_r      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.freeze       = freeze_r;
   assign bus.serve        = serve_r;
   assign bus.game_rst     = game_rst_r;
   assign bus.gameover     = gameover_r;
   assign bus.win          = win_r;
   assign bus.lives        = lives_r;
   assign bus.bricks_taken = bricks_taken_r;
   assign bus.state        = state_r;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl: stimulus pushes the expected
// snapshot and due cycle of every state change or pulse; a monitor pops and
// compares each one as the DUT presents it.
module tb_breakout_game_ctrl;
   localparam int NB = 7;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SERVE = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_MISS  = 3'd3;
   localparam logic [2:0] S_OVER  = 3'd4;
   localparam logic [2:0] S_WIN   = 3'd5;
   localparam logic [6:0] ALL     = 7'h7F;
   localparam logic [6:0] NONE    = 7'h00;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;

   logic [13:0] exp_q[$];
   int          due_q[$];
   string       name_q[$];

   breakout_game_ctrl_if #(.NUM_BRICKS(NB)) bus_if ();

   breakout_game_ctrl #(.NUM_BRICKS(NB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Snapshot layout: state, freeze, serve, game_rst, gameover, win, lives, bricks_taken
   function automatic logic [13:0] snap(input logic [2:0] st, input logic fr, input logic sv,
                                        input logic gr, input logic go, input logic wn,
                                        input logic [1:0] lv, input logic [3:0] bt);
      return {st, fr, sv, gr, go, wn, lv, bt};
   endfunction

   task automatic exp_event(input string nm, input logic [13:0] e, input int due);
      name_q.push_back(nm);
      exp_q.push_back(e);
      due_q.push_back(due);
   endtask

   task automatic drive(input logic t, input logic [1:0] b, input logic m, input logic [6:0] bp);
      @(posedge clk);
      #1;
      bus_if.tick60hz  = t;
      bus_if.btn       = b;
      bus_if.ball_miss = m;
      bus_if.brick_p   = bp;
   endtask

   task automatic run_ticks(input int n, input logic [6:0] bp, input string nm, input logic [13:0] e);
      for (int i = 1; i <= n; i++) begin
         drive(1'b1, 2'b00, 1'b0, bp);
         if (i == n && nm != "") exp_event(nm, e, cyc + 1);
         drive(1'b0, 2'b00, 1'b0, bp);
      end
   endtask

   task automatic press(input logic [1:0] b, input logic [6:0] bp, input string nm, input logic [13:0] e);
      drive(1'b0, b, 1'b0, bp);
      if (nm != "") exp_event(nm, e, cyc + 1);
      drive(1'b0, 2'b00, 1'b0, bp);
   endtask

   task automatic miss(input logic [6:0] bp, input string nm, input logic [13:0] e);
      drive(1'b0, 2'b00, 1'b1, bp);
      if (nm != "") exp_event(nm, e, cyc + 1);
      drive(1'b0, 2'b00, 1'b0, bp);
   endtask

   // Monitor: any state change or pulse is a DUT output event to be scored.
   initial begin
      logic [2:0]  prev;
      logic [13:0] act;
      logic [13:0] e;
      int          due;
      string       nm;
      prev = 3'd7;
      forever begin
         @(negedge clk);
         act = {bus_if.state, bus_if.freeze, bus_if.serve, bus_if.game_rst,
                bus_if.gameover, bus_if.win, bus_if.lives, bus_if.bricks_taken};
         if (bus_if.state != prev || bus_if.serve || bus_if.game_rst) begin
            n_total++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_event: actual snap=%h at cyc %0d, required no event", act, cyc);
            end else begin
               e   = exp_q.pop_front();
               due = due_q.pop_front();
               nm  = name_q.pop_front();
               if (act == e && (due < 0 || due == cyc)) begin
                  n_pass++;
               end else begin
                  $display("FAIL %s: actual snap=%h cyc=%0d, required snap=%h cyc=%0d", nm, act, cyc, e, due);
               end
            end
         end
         prev = bus_if.state;
      end
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required normal end");
      $fatal(1);
   end

   initial begin
      reset            = 1'b0;
      bus_if.tick60hz  = 1'b0;
      bus_if.btn       = 2'b00;
      bus_if.ball_miss = 1'b0;
      bus_if.brick_p   = ALL;
      exp_event("reset", snap(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0), -1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;

      // Start game, auto-serve after 60 ticks.
      press(2'b01, ALL, "start", snap(S_SERVE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0));
      run_ticks(60, ALL, "auto_serve", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0));

      // Lose all three balls; buttons in MISS and misses in SERVE are ignored.
      miss(ALL, "miss_3to2", snap(S_MISS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      press(2'b11, ALL, "", 14'd0);
      run_ticks(90, ALL, "miss_done_2", snap(S_SERVE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      miss(ALL, "", 14'd0);
      run_ticks(60, ALL, "serve_2", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      miss(ALL, "miss_2to1", snap(S_MISS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0));
      run_ticks(90, ALL, "miss_done_1", snap(S_SERVE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0));
      run_ticks(60, ALL, "serve_1", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd0));
      miss(ALL, "last_ball", snap(S_OVER, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0));

      // OVER: early press ignored, hold counter saturates, later press exits.
      run_ticks(50, ALL, "", 14'd0);
      press(2'b10, ALL, "", 14'd0);
      run_ticks(75, ALL, "", 14'd0);
      press(2'b10, ALL, "over_exit", snap(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0));

      // New game, button serve, last brick cleared together with a miss.
      press(2'b01, ALL, "restart", snap(S_SERVE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0));
      press(2'b10, ALL, "press_serve", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0));
      drive(1'b0, 2'b00, 1'b0, 7'b0101010);
      drive(1'b0, 2'b00, 1'b0, 7'b0000001);
      drive(1'b0, 2'b00, 1'b1, NONE);
      exp_event("clear_and_miss", snap(S_WIN, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'd7), cyc + 1);
      drive(1'b0, 2'b00, 1'b0, NONE);

      // WIN: press one tick short of the hold is ignored, press at the hold exits.
      run_ticks(119, NONE, "", 14'd0);
      press(2'b01, NONE, "", 14'd0);
      run_ticks(1, NONE, "", 14'd0);
      press(2'b01, NONE, "win_exit", snap(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd7));

      // Reset in the middle of play.
      press(2'b01, ALL, "start_3", snap(S_SERVE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'd0));
      press(2'b01, ALL, "serve_3", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0));
      miss(ALL, "miss_3b", snap(S_MISS, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      run_ticks(90, ALL, "miss_done_3b", snap(S_SERVE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      press(2'b10, ALL, "serve_3b", snap(S_PLAY, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'd0));
      drive(1'b0, 2'b00, 1'b0, 7'b1111110);
      drive(1'b0, 2'b00, 1'b0, 7'b1111110);
      @(posedge clk);
      #2 reset = 1'b0;
      exp_event("async_reset", snap(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0), cyc);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (10) drive(1'b0, 2'b00, 1'b0, ALL);

      // Drain: every expected event must have been seen.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
      while (exp_q.size() > 0) begin
         n_total++;
         $display("FAIL %s: actual no event, required snap=%h at cyc %0d",
                  name_q.pop_front(), exp_q.pop_front(), due_q.pop_front());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
